// File: rtl/cheat_code_loader.sv
// cheat_code_loader: assembles 129-bit cheat code words from a host byte
// stream and presents them to the cheat engine with a rising strobe on bit 128.
// Also issues the engine clear pulse on a clear command.
// Optional feature macro: CHEAT_LOADER_CRC_EN (adds a CRC-8 byte to add records).
module cheat_code_loader #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  input  logic [7:0]             s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [128:0]           code_out,
  output logic                   codes_reset,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] commit_count,
  output logic                   err_len,
  output logic                   err_cmd,
  output logic                   err_crc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_STROBE_HI,
    S_STROBE_LO,
    S_CLEAR
  } state_e;

  localparam int unsigned   TW       = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [7:0]    CMD_ADD  = 8'h01;
  localparam logic [7:0]    CMD_CLR  = 8'h02;
`ifdef CHEAT_LOADER_CRC_EN
  localparam logic [4:0]    LAST_BYTE = 5'd17;
`else
  localparam logic [4:0]    LAST_BYTE = 5'd16;
`endif

  state_e                 state_q, state_d;
  logic [127:0]           shadow_q, shadow_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [128:0]           code_q, code_d;
  logic                   codes_reset_q, codes_reset_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_len_q, err_len_d;
  logic                   err_cmd_q, err_cmd_d;
  logic                   accept;
  logic [4:0]             byte_num;

`ifdef CHEAT_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       err_crc_q, err_crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign err_crc = err_crc_q;
`else
  assign err_crc = 1'b0;
`endif

  assign s_ready      = (state_q == S_IDLE) || (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign accept       = s_valid && s_ready;
  assign byte_num     = cnt_q + 5'd1;
  assign busy         = (state_q != S_IDLE);
  assign code_out     = code_q;
  assign codes_reset  = codes_reset_q;
  assign commit_count = count_q;
  assign err_len      = err_len_q;
  assign err_cmd      = err_cmd_q;

  // Next-state and next-output computation for the record parser and strobe sequencer.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    code_d        = code_q;
    codes_reset_d = codes_reset_q;
    count_d       = count_q;
    err_len_d     = 1'b0;
    err_cmd_d     = 1'b0;
`ifdef CHEAT_LOADER_CRC_EN
    crc_d         = crc_q;
    err_crc_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (s_data == CMD_ADD) begin
            if (!s_last) begin
              state_d  = S_COLLECT;
              cnt_d    = '0;
              shadow_d = '0;
`ifdef CHEAT_LOADER_CRC_EN
              crc_d    = '0;
`endif
            end else begin
              err_len_d = 1'b1;
            end
          end else if (s_data == CMD_CLR) begin
            if (s_last) begin
              state_d       = S_CLEAR;
              tmr_d         = '0;
              codes_reset_d = 1'b1;
            end else begin
              err_len_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end else begin
            err_cmd_d = 1'b1;
            state_d   = s_last ? S_IDLE : S_DRAIN;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          cnt_d = byte_num;
          if (cnt_q < 5'd16) begin
            shadow_d = {shadow_q[119:0], s_data};
`ifdef CHEAT_LOADER_CRC_EN
            crc_d    = crc8_step(crc_q, s_data);
`endif
          end
          if (byte_num < LAST_BYTE) begin
            if (s_last) begin
              err_len_d = 1'b1;
              state_d   = S_IDLE;
            end
          end else if (!s_last) begin
            err_len_d = 1'b1;
            state_d   = S_DRAIN;
          end else begin
`ifdef CHEAT_LOADER_CRC_EN
            // The final byte is the CRC, so the word comes from the shadow as it stands.
            if (s_data == crc_q) begin
              state_d = S_STROBE_HI;
              tmr_d   = '0;
              code_d  = {1'b1, shadow_q};
            end else begin
              err_crc_d = 1'b1;
              state_d   = S_IDLE;
            end
`else
            // Word is loaded with the 16th byte merged in so bit 128 rises one cycle after accept.
            state_d = S_STROBE_HI;
            tmr_d   = '0;
            code_d  = {1'b1, shadow_q[119:0], s_data};
`endif
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_last) begin
          state_d = S_IDLE;
        end
      end
      S_STROBE_HI: begin
        if (tmr_q == TMR_LAST) begin
          state_d     = S_STROBE_LO;
          tmr_d       = '0;
          code_d[128] = 1'b0;
          count_d     = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_STROBE_LO: begin
        if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CLEAR: begin
        if (tmr_q == TMR_LAST) begin
          state_d       = S_IDLE;
          codes_reset_d = 1'b0;
          count_d       = '0;
          code_d        = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any partial record and drops the strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      cnt_q         <= '0;
      tmr_q         <= '0;
      code_q        <= '0;
      codes_reset_q <= 1'b0;
      count_q       <= '0;
      err_len_q     <= 1'b0;
      err_cmd_q     <= 1'b0;
`ifdef CHEAT_LOADER_CRC_EN
      crc_q         <= '0;
      err_crc_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      code_q        <= code_d;
      codes_reset_q <= codes_reset_d;
      count_q       <= count_d;
      err_len_q     <= err_len_d;
      err_cmd_q     <= err_cmd_d;
`ifdef CHEAT_LOADER_CRC_EN
      crc_q         <= crc_d;
      err_crc_q     <= err_crc_d;
`endif
    end
  end

endmodule

// File: doc/cheat_code_loader.md
Name: cheat_code_loader

Overview:
- Producer side of the cheat-code interface: accepts a byte stream from the host link (ESP32 command path) and assembles 129-bit code words of the form {strobe, flags[31:0], addr[31:0], compare[31:0], replace[31:0]}.
- Presents each assembled word to the cheat engine and generates the rising-edge strobe on bit 128 that the engine detects.
- Also issues the engine's clear pulse on a clear command.
- Sits between the host command decoder and the cheat engine, in the same clock domain as the engine.

Parameters:
- STROBE_CYCLES, 2: cycles bit 128 is held high, then held low, per commit; must be ≥1.
- COUNT_WIDTH, 8: width of commit_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks final byte of a record
- s_ready  out  1  loader can accept a byte
- code_out  out  129  code word to engine; [128] is the strobe
- codes_reset  out  1  clear pulse to engine
- busy  out  1  high in any state other than IDLE
- commit_count  out  COUNT_WIDTH  committed codes since last clear; saturating
- err_len  out  1  1-cycle pulse: record length wrong
- err_cmd  out  1  1-cycle pulse: unknown command byte
- err_crc  out  1  1-cycle pulse: CRC mismatch (optional feature only)

Behaviour:
- Byte transfer: a byte is accepted on a cycle with s_valid && s_ready. s_ready=1 only in IDLE, COLLECT and DRAIN.
- Record format:
  - 0x01 followed by 16 payload bytes: add code. Payload arrives MSB-first; first byte goes to code[127:120], 16th byte to code[7:0].
  - 0x02 with s_last: clear.
- States:
  - IDLE: on accept of 0x01 without s_last, go to COLLECT and zero the byte counter.
  - IDLE, 0x02 with s_last: go to CLEAR.
  - IDLE, 0x01 or 0x02 with the wrong s_last: pulse err_len. Go to DRAIN if s_last=0, else stay in IDLE.
  - IDLE, any other command: pulse err_cmd. Go to DRAIN if s_last=0, else stay in IDLE.
  - COLLECT: shift each byte into a 128-bit shadow register and increment the 5-bit counter.
  - COLLECT, s_last on bytes 1-15: pulse err_len, go to IDLE, discard the shadow.
  - COLLECT, byte 16 without s_last: pulse err_len, go to DRAIN.
  - COLLECT, byte 16 with s_last: go to STROBE_HI.
  - DRAIN: accept and discard bytes until one with s_last, then go to IDLE.
  - STROBE_HI: on entry, code_out[127:0] ← shadow and code_out[128]=1. Hold for STROBE_CYCLES cycles, then go to STROBE_LO.
  - STROBE_LO: code_out[128]=0 and [127:0] unchanged for STROBE_CYCLES cycles. commit_count increments by 1 on entry, saturating at all-ones. Then go to IDLE.
  - CLEAR: codes_reset=1 for STROBE_CYCLES cycles, then go to IDLE. On exit, commit_count←0 and code_out←0.
- Latency: the 16th payload byte accepted at cycle N gives code_out[128]=1 at N+1. The next byte can be accepted at N+1+2·STROBE_CYCLES.
- code_out[127:0] changes only on entry to STROBE_HI or on exit from CLEAR. It is stable whenever bit 128 rises.
- Reset (reset_n=0 at a clock edge):
  - Outputs: code_out=0, codes_reset=0, busy=0, commit_count=0, all error pulses 0.
  - s_ready=1 from the first cycle after release.
  - State returns to IDLE and any partial record is discarded.
  - Reset never asserts codes_reset. Reset in the middle of STROBE_HI drops bit 128 immediately.
- s_valid=0 in the middle of a record: wait indefinitely with no timeout.
- s_data is ignored when s_valid=0.

Optional Feature:
- CHEAT_LOADER_CRC_EN defined:
  - An add record carries a 17th byte: CRC-8 (poly 0x07, init 0x00, MSB-first, no reflect) over the 16 payload bytes. s_last is then expected on byte 17.
  - On mismatch: pulse err_crc, go to IDLE, no strobe, commit_count unchanged.
- Not defined: 16-byte payload as above, err_crc tied to 0.

Test Plan:
- Add record 0x01, 00000001 0000C000 000000AA 00000055, last on byte 16 → code_out[127:0]=0x00000001_0000C000_000000AA_00000055; bit128 high 2 cycles then low 2 cycles; commit_count=1; s_ready low for 4 cycles.
- Three back-to-back add records with s_valid held high → exactly 3 rising edges on bit 128; commit_count=3; word bits stable on every rising edge.
- 0x02 with last after 2 commits → codes_reset high 2 cycles; commit_count=0; code_out=0.
- Add record with s_last on 10th payload byte → err_len pulse; no strobe; next valid record commits normally.
- Command 0x7F followed by 4 bytes, last on 4th → err_cmd pulse; 4 bytes drained; returns to IDLE; no strobe.
- reset_n low during STROBE_HI → code_out=0 next cycle; busy=0; a following record commits correctly. With CRC_EN, a bad CRC byte → err_crc pulse and no strobe.
